// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
//
// Receives 8N1 bytes on a UART line and packs them little-endian into 32-bit
// words. Each completed word is written to memory port B with a single-cycle
// web strike. The CPU is held in reset until WORDS words have been written.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (434 = 50 MHz / 115200)
//   WORDS         number of 32-bit words to load before done
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   asynchronous serial input, 8N1, idle high
//   tx         out  serial output, idle high (echo of accepted bytes)
//   web        out  write strike, memory port B
//   addrb      out  word address, memory port B
//   dinb       out  write data, memory port B
//   cpu_hold   out  high while loading; drops when done
//   done       out  high once WORDS words are written
//   frame_err  out  sticky flag, set on any byte with a low stop bit
//
// Build option:
//   LOADER_ECHO_EN  when defined, every accepted byte is retransmitted on tx.
//                   When undefined, tx is tied high and no transmitter exists.
// -----------------------------------------------------------------------------
module uart_mem_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int WORDS        = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        tx,
   output logic        web,
   output logic [9:0]  addrb,
   output logic [31:0] dinb,
   output logic        cpu_hold,
   output logic        done,
   output logic        frame_err
);

   localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [9:0]        LAST_AD = 10'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   rx_state_t        state, state_nx;
   logic             rx_meta, rx_sync, rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       rx_shift;
   logic [1:0]       byte_idx;
   logic             cnt_clr, bit_take, byte_ok, byte_bad;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   // Reset to the idle-high level so reset release never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments give every flop the pre-edge value of
         // its source; blocking here would collapse the chain into one stage.
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nx = state;
      cnt_clr  = 1'b0;
      bit_take = 1'b0;
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
      case (state)
         IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_nx = START;
               cnt_clr  = 1'b1;
            end
         end
         START: begin
            // Mid start bit: still low means a real start, high means a glitch.
            if (cnt == HALF_M1) begin
               cnt_clr  = 1'b1;
               state_nx = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               bit_take = 1'b1;
               if (bit_idx == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               state_nx = IDLE;
               byte_ok  = rx_sync;
               byte_bad = !rx_sync;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bit timing and LSB-first shift register. bit_idx wraps 7 -> 0 on the
   // last data bit, so it is already 0 for the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         bit_idx  <= 3'd0;
         rx_shift <= 8'd0;
      end else begin
         if (cnt_clr)             cnt <= '0;
         else if (state != IDLE)  cnt <= cnt + CNT_W'(1);
         if (bit_take) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
         end
      end
   end

   // Word packing and memory-port control. A rejected byte leaves byte_idx
   // and the partial word untouched; after done, bytes are ignored entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx  <= 2'd0;
         dinb      <= 32'd0;
         web       <= 1'b0;
         addrb     <= 10'd0;
         done      <= 1'b0;
         cpu_hold  <= 1'b1;
         frame_err <= 1'b0;
      end else begin
         web <= 1'b0;
         if (byte_bad) frame_err <= 1'b1;
         if (byte_ok && !done) begin
            dinb[{byte_idx, 3'b000} +: 8] <= rx_shift;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) web <= 1'b1;
         end
         // Bytes are a full frame apart, so web can never be set two cycles
         // running; the address advances in the cycle after each strike.
         if (web) begin
            if (addrb == LAST_AD) begin
               done     <= 1'b1;
               cpu_hold <= 1'b0;
            end else begin
               addrb <= addrb + 10'd1;
            end
         end
      end
   end

`ifdef LOADER_ECHO_EN
   // 8N1 echo transmitter. tx_shift idles at all ones, so its LSB is the line.
   // A byte accepted while busy is simply not echoed.
   logic             tx_busy;
   logic [9:0]       tx_shift;
   logic [3:0]       tx_bits;
   logic [CNT_W-1:0] tx_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy  <= 1'b0;
         tx_shift <= 10'h3FF;
         tx_bits  <= 4'd0;
         tx_cnt   <= '0;
      end else if (!tx_busy) begin
         if (byte_ok) begin
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, rx_shift, 1'b0};
            tx_bits  <= 4'd0;
            tx_cnt   <= '0;
         end
      end else if (tx_cnt == FULL_M1) begin
         tx_cnt   <= '0;
         tx_shift <= {1'b1, tx_shift[9:1]};
         if (tx_bits == 4'd9) tx_busy <= 1'b0;
         else                 tx_bits <= tx_bits + 4'd1;
      end else begin
         tx_cnt <= tx_cnt + CNT_W'(1);
      end
   end

   assign tx = tx_shift[0];
`else
   assign tx = 1'b1;
`endif

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter WORDS, default 512, giving the number of 32-bit words loaded before completion.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1 bit, sole clock; all flops on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port rx, input, 1 bit, asynchronous RS232 serial input, 8N1, idle high.
REQ-006 Port tx, output, 1 bit, RS232 serial output, idle high.
REQ-007 Port web, output, 1 bit, write strike to memory port B.
REQ-008 Port addrb, output, 10 bits, memory port B word address.
REQ-009 Port dinb, output, 32 bits, memory port B write data.
REQ-010 Port cpu_hold, output, 1 bit, holds the CPU in reset while loading.
REQ-011 Port done, output, 1 bit, high once WORDS words are written.
REQ-012 Port frame_err, output, 1 bit, sticky framing-error flag.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
REQ-015 In START the line SHALL be resampled after CLKS_PER_BIT/2 cycles.
- Low -> DATA.
- High -> IDLE (glitch rejected, no byte, no error).
REQ-016 In DATA, 8 bits SHALL be sampled every CLKS_PER_BIT cycles, LSB first; after bit 7 the FSM SHALL go to STOP.
REQ-017 In STOP the line SHALL be sampled after CLKS_PER_BIT cycles.
- High: byte accepted.
- Low: byte discarded, frame_err set to 1.
- Either way the FSM returns to IDLE.
REQ-018 Accepted bytes SHALL be packed little-endian: byte k of a word goes to dinb[8k+7:8k], k = 0..3.
REQ-019 On acceptance of byte 3, web SHALL pulse high for exactly one cycle in the next cycle, with dinb holding the full word and addrb the current address.
REQ-020 addrb SHALL increment by 1 in the cycle after each web pulse; the byte index SHALL return to 0.
REQ-021 After the WORDS-th write, done SHALL go to 1 and cpu_hold to 0 in the same cycle addrb would increment; addrb SHALL then hold WORDS-1.
REQ-022 While done = 1, received bytes SHALL NOT cause writes; the receiver keeps running and frame_err stays live.
REQ-023 A framing error SHALL NOT advance the byte index; the partial word is preserved.
REQ-024 web SHALL never be high in two consecutive cycles.

Reset
REQ-025 While rst = 1, all outputs and internal state SHALL clear asynchronously:
- tx = 1, web = 0, addrb = 0, dinb = 0, cpu_hold = 1, done = 0, frame_err = 0.
- FSM in IDLE, byte index 0.
REQ-026 A reset asserted mid-byte or mid-word SHALL discard all partial data; loading restarts at address 0.

Configuration
REQ-027 With macro LOADER_ECHO_EN defined, an 8N1 transmitter SHALL retransmit each accepted byte on tx at CLKS_PER_BIT.
- Transmission starts within 2 cycles of acceptance.
- A byte arriving while a transmission is in progress is dropped from the echo only; the memory write is unaffected.
REQ-028 Without LOADER_ECHO_EN, tx SHALL be constant 1 and no transmitter logic SHALL exist.

Verification (CLKS_PER_BIT = 16, WORDS = 4)
REQ-029 Send bytes 0x78, 0x56, 0x34, 0x12 -> one web pulse, addrb = 0, dinb = 0x12345678; addrb = 1 afterwards.
REQ-030 Send 16 bytes -> four writes to addresses 0..3, then done = 1 and cpu_hold = 0; a 17th byte produces no web.
REQ-031 Low pulse on rx of 4 cycles -> no byte accepted, frame_err = 0.
REQ-032 Send byte 0xAA with stop bit low, then 0x11, 0x22, 0x33, 0x44 -> frame_err = 1, single write with dinb = 0x44332211.
REQ-033 Assert rst after 2 bytes, then send 4 fresh bytes -> write lands at addrb = 0 containing only the fresh bytes.
REQ-034 With LOADER_ECHO_EN, send 0x5A -> tx emits start, 0,1,0,1,1,0,1,0, stop at 16 cycles/bit; without the macro, tx stays 1.
